// File: rtl/mult_seq_ctrl_if.sv
// Start/done handshake bundle between an issuing datapath and mult_seq_ctrl.
// The master drives the request side; the slave (the multiplier) drives status and result.
interface mult_seq_ctrl_if #(
    parameter int SIZE = 4
);
    logic            start;
    logic [SIZE-1:0] A;
    logic [SIZE-1:0] B;
    logic            busy;
    logic            done;
    logic [SIZE-1:0] HM;
    logic [SIZE-1:0] LM;

    modport master (output start, A, B, input busy, done, HM, LM);
    modport slave  (input start, A, B, output busy, done, HM, LM);
endinterface

// File: rtl/mult_seq_ctrl.sv
// Iterative unsigned shift-and-add multiplier, one ripple add per clock, IDLE/RUN/DONE sequencer.
// Optional MULT_SEQ_ZERO_SKIP_EN: zero operands bypass RUN and complete in one cycle.
module mult_seq_ctrl #(
    parameter int SIZE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mult_seq_ctrl_if.slave     bus
);
    localparam int CW = $clog2(SIZE) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [SIZE-1:0] a_r;
    logic [SIZE-1:0] hi_acc_r;
    logic [SIZE-1:0] lo_sh_r;
    logic [CW-1:0]   cnt_r;
    logic [SIZE-1:0] hm_r;
    logic [SIZE-1:0] lm_r;
    logic            busy_r;
    logic            done_r;
    logic            accept_s;
    logic            zero_s;
    logic            last_s;
    logic [SIZE-1:0] gated_s;
    logic [SIZE:0]   sum_s;

    // Bit-level ripple-carry add; carry out is returned as the MSB so it is never dropped.
    function automatic logic [SIZE:0] ripple_add(input logic [SIZE-1:0] x, input logic [SIZE-1:0] y);
        logic [SIZE:0]   c;
        logic [SIZE-1:0] s;
        c[0] = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        return {c[SIZE], s};
    endfunction

    // Next-state decode plus the accept/last strobes used by the datapath.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        last_s       = 1'b0;
        gated_s      = a_r & {SIZE{lo_sh_r[0]}};
        sum_s        = ripple_add(hi_acc_r, gated_s);
`ifdef MULT_SEQ_ZERO_SKIP_EN
        zero_s       = (bus.A == {SIZE{1'b0}}) || (bus.B == {SIZE{1'b0}});
`else
        zero_s       = 1'b0;
`endif
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    accept_s = 1'b1;
                    if (zero_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == LAST_CNT) begin
                    last_s       = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture, shift-add step and registered status/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= {SIZE{1'b0}};
            hi_acc_r <= {SIZE{1'b0}};
            lo_sh_r  <= {SIZE{1'b0}};
            cnt_r    <= {CW{1'b0}};
            hm_r     <= {SIZE{1'b0}};
            lm_r     <= {SIZE{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            busy_r <= (state_next_s == ST_RUN);
            done_r <= (state_next_s == ST_DONE);
            if (accept_s) begin
                a_r      <= bus.A;
                lo_sh_r  <= bus.B;
                hi_acc_r <= {SIZE{1'b0}};
                cnt_r    <= {CW{1'b0}};
                if (zero_s) begin
                    hm_r <= {SIZE{1'b0}};
                    lm_r <= {SIZE{1'b0}};
                end
            end else if (state_r == ST_RUN) begin
                // Carry lands in hi_acc MSB; the consumed multiplier bit falls off lo_sh.
                {hi_acc_r, lo_sh_r} <= {sum_s, lo_sh_r[SIZE-1:1]};
                cnt_r               <= cnt_r + CW'(1);
                if (last_s) begin
                    hm_r <= sum_s[SIZE:1];
                    lm_r <= {sum_s[0], lo_sh_r[SIZE-1:1]};
                end
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.HM   = hm_r;
    assign bus.LM   = lm_r;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl (SIZE=4): handshake timing, result values, reset abort, full sweep.
module tb_mult_seq_ctrl;
    localparam int SIZE = 4;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    mult_seq_ctrl_if #(.SIZE(SIZE)) bus_if ();

    mult_seq_ctrl #(.SIZE(SIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus_if.start = 1'b0;
        bus_if.A     = 4'd0;
        bus_if.B     = 4'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus_if.busy, bus_if.done, bus_if.HM, bus_if.LM} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b HM=%h LM=%h, want all 0",
                     bus_if.busy, bus_if.done, bus_if.HM, bus_if.LM);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        bus_if.start = 1'b1;
        bus_if.A     = 4'd15;
        bus_if.B     = 4'd15;
        for (int k = 0; k <= 5; k++) begin
            step();
            bus_if.start = 1'b0;
            checks++;
            if (bus_if.busy !== (k <= 3) || bus_if.done !== (k == 4)) begin
                errors++;
                $display("FAIL basic_handshake k=%0d: got busy=%b done=%b, want busy=%b done=%b",
                         k, bus_if.busy, bus_if.done, (k <= 3), (k == 4));
            end
            if (k <= 3) begin
                checks++;
                if ({bus_if.HM, bus_if.LM} !== 8'h00) begin
                    errors++;
                    $display("FAIL basic_hold k=%0d: got %h%h, want 00", k, bus_if.HM, bus_if.LM);
                end
            end
            if (k == 4) begin
                checks++;
                if (bus_if.HM !== 4'hE || bus_if.LM !== 4'h1) begin
                    errors++;
                    $display("FAIL basic_15x15: got HM=%h LM=%h, want HM=e LM=1", bus_if.HM, bus_if.LM);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bus_if.start = 1'b1;
        bus_if.A     = 4'd7;
        bus_if.B     = 4'd3;
        for (int k = 0; k <= 9; k++) begin
            step();
            checks++;
            if (bus_if.done !== (k == 4 || k == 9) || bus_if.busy !== !(k == 4 || k == 9)) begin
                errors++;
                $display("FAIL b2b_handshake k=%0d: got busy=%b done=%b, want done=%b",
                         k, bus_if.busy, bus_if.done, (k == 4 || k == 9));
            end
            if (k == 4 || k == 9) begin
                checks++;
                if (bus_if.HM !== 4'h1 || bus_if.LM !== 4'h5) begin
                    errors++;
                    $display("FAIL b2b_7x3 k=%0d: got HM=%h LM=%h, want HM=1 LM=5", k, bus_if.HM, bus_if.LM);
                end
            end
        end
        bus_if.start = 1'b0;
        step();
    endtask

    task automatic test_ignore_midrun();
        bus_if.start = 1'b1;
        bus_if.A     = 4'd5;
        bus_if.B     = 4'd6;
        for (int k = 0; k <= 5; k++) begin
            step();
            bus_if.start = (k == 1);
            bus_if.A     = (k == 1) ? 4'd1 : 4'd5;
            bus_if.B     = (k == 1) ? 4'd1 : 4'd6;
            checks++;
            if (bus_if.done !== (k == 4) || bus_if.busy !== (k <= 3)) begin
                errors++;
                $display("FAIL ignore_handshake k=%0d: got busy=%b done=%b", k, bus_if.busy, bus_if.done);
            end
            checks++;
            if (k <= 3 && {bus_if.HM, bus_if.LM} !== 8'h15) begin
                errors++;
                $display("FAIL ignore_hold k=%0d: got %h%h, want 15", k, bus_if.HM, bus_if.LM);
            end else if (k >= 4 && {bus_if.HM, bus_if.LM} !== 8'h1E) begin
                errors++;
                $display("FAIL ignore_5x6 k=%0d: got %h%h, want 1e", k, bus_if.HM, bus_if.LM);
            end
        end
    endtask

    task automatic test_zero();
        bus_if.start = 1'b1;
        bus_if.A     = 4'd9;
        bus_if.B     = 4'd0;
        for (int k = 0; k <= 5; k++) begin
            logic exp_busy;
            logic exp_done;
            step();
            bus_if.start = 1'b0;
`ifdef MULT_SEQ_ZERO_SKIP_EN
            exp_busy = 1'b0;
            exp_done = (k == 0);
`else
            exp_busy = (k <= 3);
            exp_done = (k == 4);
`endif
            checks++;
            if (bus_if.busy !== exp_busy || bus_if.done !== exp_done) begin
                errors++;
                $display("FAIL zero_handshake k=%0d: got busy=%b done=%b, want busy=%b done=%b",
                         k, bus_if.busy, bus_if.done, exp_busy, exp_done);
            end
            if (exp_done) begin
                checks++;
                if ({bus_if.HM, bus_if.LM} !== 8'h00) begin
                    errors++;
                    $display("FAIL zero_9x0: got %h%h, want 00", bus_if.HM, bus_if.LM);
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        bus_if.start = 1'b1;
        bus_if.A     = 4'd12;
        bus_if.B     = 4'd11;
        step();
        bus_if.start = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_if.busy, bus_if.done, bus_if.HM, bus_if.LM} !== 10'd0) begin
            errors++;
            $display("FAIL abort_outputs: got busy=%b done=%b HM=%h LM=%h, want all 0",
                     bus_if.busy, bus_if.done, bus_if.HM, bus_if.LM);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet k=%0d: got busy=%b done=%b, want 0 0", k, bus_if.busy, bus_if.done);
            end
        end
        bus_if.start = 1'b1;
        bus_if.A     = 4'd2;
        bus_if.B     = 4'd3;
        for (int k = 0; k <= 4; k++) begin
            step();
            bus_if.start = 1'b0;
        end
        checks++;
        if (bus_if.done !== 1'b1 || bus_if.HM !== 4'h0 || bus_if.LM !== 4'h6) begin
            errors++;
            $display("FAIL abort_2x3: got done=%b HM=%h LM=%h, want 1 0 6", bus_if.done, bus_if.HM, bus_if.LM);
        end
        step();
    endtask

    task automatic test_sweep();
        int done_cnt;
        int cyc;
        int exp_lat;
        logic [7:0] exp_p;
        done_cnt     = 0;
        bus_if.start = 1'b1;
        bus_if.A     = 4'd0;
        bus_if.B     = 4'd0;
        for (int n = 0; n < 256; n++) begin
            exp_p   = 8'(n[7:4] * n[3:0]);
            exp_lat = SIZE + 1;
`ifdef MULT_SEQ_ZERO_SKIP_EN
            if (n[7:4] == 0 || n[3:0] == 0) exp_lat = 1;
`endif
            cyc = 0;
            do begin
                step();
                cyc++;
            end while (bus_if.done !== 1'b1 && cyc < 12);
            checks++;
            if (bus_if.done !== 1'b1 || cyc != exp_lat) begin
                errors++;
                $display("FAIL sweep_latency A=%0d B=%0d: got %0d cycles done=%b, want %0d",
                         n[7:4], n[3:0], cyc, bus_if.done, exp_lat);
            end else begin
                done_cnt++;
            end
            checks++;
            if ({bus_if.HM, bus_if.LM} !== exp_p) begin
                errors++;
                $display("FAIL sweep_product A=%0d B=%0d: got %h, want %h",
                         n[7:4], n[3:0], {bus_if.HM, bus_if.LM}, exp_p);
            end
            bus_if.start = (n != 255);
            bus_if.A     = 4'((n + 1) >> 4);
            bus_if.B     = 4'(n + 1);
        end
        checks++;
        if (done_cnt != 256) begin
            errors++;
            $display("FAIL sweep_done_count: got %0d, want 256", done_cnt);
        end
        step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_midrun();
        test_zero();
        test_reset_midrun();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Iterative shift-and-add multiplier: one SIZE-bit ripple add (yAdder-style, with carry out) per clock, sequenced by a small FSM.
- Replaces the fully unrolled SIZE-stage array multiplier when area matters more than latency.
- Start/done handshake toward the issuing datapath.
- Result is presented as high and low halves, HM and LM.

Parameters:
- SIZE, default 4, operand width in bits; product is 2*SIZE bits split into HM (high) and LM (low).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiply; sampled only when not busy.
- A  input  SIZE  multiplicand, captured on the accepted start edge.
- B  input  SIZE  multiplier, captured on the accepted start edge.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse; HM/LM are valid with it.
- HM  output  SIZE  high half of A*B (unsigned).
- LM  output  SIZE  low half of A*B (unsigned).

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE.
  - busy=0, done=0, HM=0, LM=0.
  - Internal regs cleared: a_reg, hi_acc, lo_sh, cnt.
- States:
  - IDLE: waiting for start.
  - RUN: one multiplier bit processed per cycle.
  - DONE: one-cycle completion state.
- IDLE, start=1 at an edge:
  - a_reg<=A, lo_sh<=B, hi_acc<=0, cnt<=0.
  - Go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each edge:
  - gated = a_reg AND {SIZE{lo_sh[0]}}.
  - {c,sum} = hi_acc + gated, with cin=0.
  - {hi_acc,lo_sh} <= {c,sum,lo_sh[SIZE-1:1]}, a right shift of the (2*SIZE+1)-bit concatenation dropping its LSB.
  - cnt<=cnt+1.
  - When cnt==SIZE-1 at the edge, go to DONE.
  - Capture HM<=the new hi_acc value and LM<=the new lo_sh value on that same edge.
- DONE:
  - done=1 for exactly this cycle.
  - Next edge: if start=1, perform the IDLE capture actions and go to RUN (back-to-back issue); otherwise go to IDLE.
- Latency: start sampled at edge E0 → done high during the cycle after edge E(SIZE) (SIZE RUN cycles).
- Throughput: one result per SIZE+1 cycles.
- start while RUN: ignored. No queuing and no error flag.
- A/B are don't-care except on the accepting edge.
- HM/LM hold the last completed result until the next completion; they do not change during RUN.
- Counter width: $clog2(SIZE)+1 bits, no wrap.
- cnt is cleared on every accept.
- Reset mid-RUN: the operation is aborted, outputs return to reset values, and no done pulse is generated.
- Arithmetic is unsigned only; the carry out of the add is never lost (it shifts into hi_acc MSB).
- Outputs are registered; there is no combinational path from inputs to any output.

Optional Feature:
- Macro: MULT_SEQ_ZERO_SKIP_EN.
- When defined, on an accepted start where A==0 or B==0:
  - FSM goes directly IDLE→DONE, skipping RUN.
  - HM<=0 and LM<=0 on the accept edge.
  - done is high in the following cycle (latency 1).
  - busy never asserts.
- The same skip applies to an accept taken from DONE.
- When not defined, zero operands take the full SIZE-cycle RUN path and yield 0.

Test Plan:
- Reset, then A=15, B=15, start one cycle → busy high 4 cycles; done pulse on the 5th cycle after accept; HM=4'hE, LM=4'h1; busy=0 with done.
- A=7, B=3 → HM=4'h1, LM=4'h5. Hold start=1 for the whole op: exactly one done pulse; a second op starts from the DONE cycle, and its done arrives 5 cycles after the first.
- A=9, B=0 → without the macro: 4 busy cycles, result 0. With MULT_SEQ_ZERO_SKIP_EN: done the cycle after accept, busy never high, HM=LM=0.
- Start A=5, B=6; mid-RUN pulse start with A=1, B=1 → ignored; result HM=4'h1, LM=4'hE (30); HM/LM unchanged from the prior result until this done.
- Start A=12, B=11; drop rst_n asynchronously during the 2nd RUN cycle → immediate busy=0, done=0, HM=LM=0; no done after release. A new op A=2, B=3 then gives LM=6.
- Exhaustive sweep over all 256 A,B pairs, back-to-back → every {HM,LM}==A*B; done count=256.
